hs_delay_valid_data_slice: RTL and testbench
============================================

Name: hs_delay_valid_data_slice

Overview:
- Forward-registered valid/ready pipeline slice. Delays up_valid/up_data by STAGES register stages toward the downstream consumer.
- up_ready stays a combinational function of stage occupancy and down_ready, so there is no backward register and no skid buffer.
- Placed between streaming producer/consumer blocks to cut the valid/data timing path while keeping full throughput.

Parameters:
- WORD_WIDTH, 8, payload width in bits.
- STAGES, 1, number of cascaded forward stages. Legal range is 1..8; other values raise an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- up_valid  in  1  upstream data valid.
- up_data  in  WORD_WIDTH  upstream payload.
- up_ready  out  1  slice can accept upstream word this cycle.
- down_valid  out  1  output stage holds a valid word.
- down_data  out  WORD_WIDTH  output payload.
- down_ready  in  1  downstream accepts word this cycle.
- occupancy  out  4  count of stages currently holding valid words, range 0..STAGES.

Behaviour:
- Each stage i holds registers v[i] and d[i]. Stage 0 is fed from the up side; stage STAGES-1 drives down_valid/down_data.
- Stage ready: rdy[i] = !v[i] || rdy[i+1]. rdy[STAGES] = down_ready. up_ready = rdy[0].
  - For STAGES=1: up_ready = down_ready || !down_valid.
- Clock edge, for each stage with rdy[i]=1:
  - v[i] <= valid_in[i].
  - d[i] <= data_in[i] only if valid_in[i]=1; otherwise d[i] holds its value.
  - Stage i with rdy[i]=0 holds v[i] and d[i].
- Transfers:
  - Upstream transfer when up_valid && up_ready.
  - Downstream transfer when down_valid && down_ready.
  - Both may occur in the same cycle: output word leaves and new word enters with no bubble.
- Latency: a word accepted at edge N appears on down_valid/down_data after edge N+STAGES-1 when no stalls occur. For STAGES=1 it is visible right after the accepting edge.
- Throughput: 1 word/cycle with down_ready held high.
- Bubbles: empty intermediate stages always accept, so gaps collapse under backpressure.
- Stall: while down_valid=1 and down_ready=0, down_data is held stable and down_valid stays high. up_valid may drop without loss of the held word.
- Ordering: words exit in acceptance order. No duplication, no loss.
- down_valid/down_data change only on clock edges. No combinational path from up_* to down_*.
- occupancy: registered popcount of v[]. It updates with v[] and is not a combinational sum.
- Reset (rst_n=0 at edge): all v[i]=0, d[i]=0, occupancy=0, down_valid=0, down_data=0.
  - During reset, up_ready reads 1 because the stages are empty; upstream must not rely on it.
  - Reset asserted mid-stream discards all held words.
  - The first edge with rst_n=1 may accept a word.

Optional Feature:
- Macro: HS_DELAY_STATS_EN.
- Defined: adds outputs in_count [15:0] and out_count [15:0].
  - in_count increments on each upstream transfer; out_count increments on each downstream transfer.
  - Both wrap 0xFFFF->0x0000 and reset to 0.
  - Invariant: in_count - out_count (mod 2^16) == occupancy.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset with STAGES=1, down_ready=0 -> down_valid=0, down_data=0x00, occupancy=0, up_ready=1.
- STAGES=1, up_valid=1, up_data=0x5A, down_ready=0 for 3 cycles:
  - Edge 1 loads 0x5A; down_valid=1, up_ready=0.
  - down_data stays 0x5A for all stall cycles and 0x5A is not overwritten.
- STAGES=1, down_ready toggling 0/1 every cycle, producer sending 0x01, 0x02, 0x03 … on each accept:
  - Output sequence 0x01, 0x02, 0x03 in order, each transferred exactly once.
  - A word is accepted only in cycles where up_ready=1.
- STAGES=1, down_ready=1 constant, up_valid=1 for 4 cycles with 0x10..0x13, then 0 for 2 cycles, then 1:
  - Back-to-back output 0x10..0x13, a 2-cycle down_valid gap, then resume.
  - No bubble inserted while valid is continuous.
- STAGES=3, down_ready=0 while 3 words 0xA1/0xA2/0xA3 are sent:
  - occupancy reaches 3 and up_ready=0.
  - Release down_ready -> 0xA1, 0xA2, 0xA3 exit on consecutive cycles; occupancy returns to 0.
- Full pipeline (STAGES=3) with rst_n pulsed low for 1 cycle -> down_valid=0 and occupancy=0 after that edge; with HS_DELAY_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/hs_delay_valid_data_slice.sv
// Forward-registered valid/ready slice: STAGES cascaded valid/data registers, combinational up_ready.
// Optional HS_DELAY_STATS_EN adds free-running 16-bit in_count/out_count transfer counters.
module hs_delay_valid_data_slice #(
    parameter int WORD_WIDTH = 8,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    input  logic [WORD_WIDTH-1:0] up_data,
    output logic                  up_ready,
    output logic                  down_valid,
    output logic [WORD_WIDTH-1:0] down_data,
    input  logic                  down_ready,
    output logic [3:0]            occupancy
`ifdef HS_DELAY_STATS_EN
    ,
    output logic [15:0]           in_count,
    output logic [15:0]           out_count
`endif
);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("hs_delay_valid_data_slice: STAGES must be in 1..8");
    end

    // Handshake: a word moves across a boundary on a clock edge where valid && ready are both high.
    logic [STAGES-1:0]     v;
    logic [STAGES-1:0]     v_next;
    logic [WORD_WIDTH-1:0] d      [STAGES];
    logic [STAGES:0]       rdy;
    logic [STAGES-1:0]     vin;
    logic [WORD_WIDTH-1:0] din    [STAGES];
    logic [3:0]            occ_next;
    logic                  all_full;

    // rdy[i] is high when down_ready is high or any stage at or after i is empty; this is the
    // unrolled form of rdy[i] = !v[i] || rdy[i+1] without a self-referencing vector.
    always_comb begin
        all_full     = 1'b1;
        rdy          = '0;
        rdy[STAGES]  = down_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            rdy[i]   = down_ready | ~all_full;
        end
    end

    always_comb begin
        vin[0] = up_valid;
        din[0] = up_data;
        for (int i = 1; i < STAGES; i++) begin
            vin[i] = v[i-1];
            din[i] = d[i-1];
        end
    end

    always_comb begin
        v_next   = v;
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
                v_next[i] = vin[i];
            end
            occ_next = occ_next + {3'b000, v_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else begin
            v         <= v_next;
            occupancy <= occ_next;
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i] && vin[i]) begin
                    d[i] <= din[i];
                end
            end
        end
    end

    assign up_ready   = rdy[0];
    assign down_valid = v[STAGES-1];
    assign down_data  = d[STAGES-1];

`ifdef HS_DELAY_STATS_EN
    logic up_fire;
    logic down_fire;

    assign up_fire   = up_valid & rdy[0];
    assign down_fire = v[STAGES-1] & down_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (up_fire) begin
                in_count <= in_count + 16'd1;
            end
            if (down_fire) begin
                out_count <= out_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hs_delay_valid_data_slice.sv
// Bench for hs_delay_valid_data_slice: one STAGES=1 and one STAGES=3 instance, each with a queue scoreboard.
module tb_hs_delay_valid_data_slice;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         s1_up_valid, s1_up_ready, s1_down_valid, s1_down_ready;
    logic [W-1:0] s1_up_data, s1_down_data;
    logic [3:0]   s1_occ;
    logic         s3_up_valid, s3_up_ready, s3_down_valid, s3_down_ready;
    logic [W-1:0] s3_up_data, s3_down_data;
    logic [3:0]   s3_occ;
`ifdef HS_DELAY_STATS_EN
    logic [15:0]  s1_in_count, s1_out_count, s3_in_count, s3_out_count;
    logic [15:0]  s1_in_m, s1_out_m, s3_in_m, s3_out_m;
`endif

    hs_delay_valid_data_slice #(.WORD_WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .up_valid(s1_up_valid), .up_data(s1_up_data), .up_ready(s1_up_ready),
        .down_valid(s1_down_valid), .down_data(s1_down_data), .down_ready(s1_down_ready),
        .occupancy(s1_occ)
`ifdef HS_DELAY_STATS_EN
        , .in_count(s1_in_count), .out_count(s1_out_count)
`endif
    );

    hs_delay_valid_data_slice #(.WORD_WIDTH(W), .STAGES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .up_valid(s3_up_valid), .up_data(s3_up_data), .up_ready(s3_up_ready),
        .down_valid(s3_down_valid), .down_data(s3_down_data), .down_ready(s3_down_ready),
        .occupancy(s3_occ)
`ifdef HS_DELAY_STATS_EN
        , .in_count(s3_in_count), .out_count(s3_out_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- scoreboards ----------------
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q3[$];
    int s1_out_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q1.delete();
`ifdef HS_DELAY_STATS_EN
            s1_in_m  = '0;
            s1_out_m = '0;
`endif
        end else begin
            check("s1_occ", 32'(s1_occ), 32'(exp_q1.size()));
            check("s1_up_ready", 32'(s1_up_ready), 32'(s1_down_ready || exp_q1.size() < 1));
            check("s1_down_valid", 32'(s1_down_valid), 32'(exp_q1.size() != 0));
`ifdef HS_DELAY_STATS_EN
            check("s1_in_count", 32'(s1_in_count), 32'(s1_in_m));
            check("s1_out_count", 32'(s1_out_count), 32'(s1_out_m));
`endif
            if (s1_up_valid && s1_up_ready) begin
                exp_q1.push_back(s1_up_data);
`ifdef HS_DELAY_STATS_EN
                s1_in_m = s1_in_m + 16'd1;
`endif
            end
            if (s1_down_valid && s1_down_ready) begin
                if (exp_q1.size() == 0) check("s1_underflow", 32'(exp_q1.size()), 32'd1);
                else check("s1_down_data", 32'(s1_down_data), 32'(exp_q1.pop_front()));
                s1_out_cnt++;
`ifdef HS_DELAY_STATS_EN
                s1_out_m = s1_out_m + 16'd1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q3.delete();
`ifdef HS_DELAY_STATS_EN
            s3_in_m  = '0;
            s3_out_m = '0;
`endif
        end else begin
            check("s3_occ", 32'(s3_occ), 32'(exp_q3.size()));
            check("s3_up_ready", 32'(s3_up_ready), 32'(s3_down_ready || exp_q3.size() < 3));
            check("s3_dv_nonempty", 32'(s3_down_valid && exp_q3.size() == 0), 32'd0);
`ifdef HS_DELAY_STATS_EN
            check("s3_in_count", 32'(s3_in_count), 32'(s3_in_m));
            check("s3_out_count", 32'(s3_out_count), 32'(s3_out_m));
`endif
            if (s3_up_valid && s3_up_ready) begin
                exp_q3.push_back(s3_up_data);
`ifdef HS_DELAY_STATS_EN
                s3_in_m = s3_in_m + 16'd1;
`endif
            end
            if (s3_down_valid && s3_down_ready) begin
                if (exp_q3.size() == 0) check("s3_underflow", 32'(exp_q3.size()), 32'd1);
                else check("s3_down_data", 32'(s3_down_data), 32'(exp_q3.pop_front()));
`ifdef HS_DELAY_STATS_EN
                s3_out_m = s3_out_m + 16'd1;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s1_up_valid = 1'b0; s1_up_data = '0; s1_down_ready = 1'b0;
        s3_up_valid = 1'b0; s3_up_data = '0; s3_down_ready = 1'b0;
    endtask

    task automatic drain(input int cycles);
        s1_up_valid = 1'b0; s3_up_valid = 1'b0;
        s1_down_ready = 1'b1; s3_down_ready = 1'b1;
        repeat (cycles) tick();
    endtask

    // ---------------- stimulus ----------------
    bit vtab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int val;
        int base;
        logic [W-1:0] nxt;
        logic acc;

        rst_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s1_dv", 32'(s1_down_valid), 32'd0);
        check("rst_s1_data", 32'(s1_down_data), 32'h00);
        check("rst_s1_occ", 32'(s1_occ), 32'd0);
        check("rst_s1_up_ready", 32'(s1_up_ready), 32'd1);
        check("rst_s3_dv", 32'(s3_down_valid), 32'd0);
        check("rst_s3_occ", 32'(s3_occ), 32'd0);
        tick();
        rst_n = 1'b1;

        // Stall with STAGES=1: 0x5A held while down_ready=0 and later data is offered.
        s1_up_valid = 1'b1; s1_up_data = 8'h5A; s1_down_ready = 1'b0;
        @(negedge clk);
        check("stall_pre_ready", 32'(s1_up_ready), 32'd1);
        tick();
        s1_up_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_dv", 32'(s1_down_valid), 32'd1);
            check("stall_up_ready", 32'(s1_up_ready), 32'd0);
            check("stall_data", 32'(s1_down_data), 32'h5A);
            tick();
        end
        drain(2);

        // down_ready toggling every cycle, producer advances only on accept.
        base = s1_out_cnt;
        val = 1;
        s1_down_ready = 1'b0;
        for (int c = 0; c < 40 && val <= 3; c++) begin
            s1_up_valid = 1'b1;
            s1_up_data  = 8'(val);
            s1_down_ready = ~s1_down_ready;
            @(negedge clk);
            acc = s1_up_valid && s1_up_ready;
            tick();
            if (acc) val++;
        end
        check("toggle_accepted", 32'(val), 32'd4);
        s1_up_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            s1_down_ready = ~s1_down_ready;
            tick();
        end
        check("toggle_out_cnt", 32'(s1_out_cnt - base), 32'd3);
        check("toggle_q_empty", 32'(exp_q1.size()), 32'd0);

        // Continuous valid then a 2-cycle gap with down_ready held high.
        s1_down_ready = 1'b1;
        nxt = 8'h10;
        for (int k = 0; k < 8; k++) begin
            s1_up_valid = vtab[k];
            s1_up_data  = vtab[k] ? nxt : 8'h00;
            if (vtab[k]) nxt = nxt + 8'd1;
            @(negedge clk);
            if (k > 0) check("gap_dv", 32'(s1_down_valid), 32'(vtab[k-1]));
            tick();
        end
        @(negedge clk);
        check("gap_dv_last", 32'(s1_down_valid), 32'(vtab[7]));
        drain(2);

        // STAGES=3 fill under backpressure, then release.
        idle_all();
        s1_down_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s3_up_valid = 1'b1;
            s3_up_data  = 8'hA1 + 8'(i);
            @(negedge clk);
            if (i > 0) check("s3_latency_dv", 32'(s3_down_valid), 32'd0);
            tick();
        end
        s3_up_data = 8'hEE;
        @(negedge clk);
        check("s3_full_occ", 32'(s3_occ), 32'd3);
        check("s3_full_up_ready", 32'(s3_up_ready), 32'd0);
        check("s3_full_dv", 32'(s3_down_valid), 32'd1);
        check("s3_full_data", 32'(s3_down_data), 32'hA1);
        tick();
        s3_up_valid = 1'b0;
        s3_down_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("s3_release_dv", 32'(s3_down_valid), 32'd1);
            check("s3_release_data", 32'(s3_down_data), 32'hA1 + 32'(j));
            tick();
        end
        @(negedge clk);
        check("s3_empty_dv", 32'(s3_down_valid), 32'd0);
        check("s3_empty_occ", 32'(s3_occ), 32'd0);

        // Reset pulse with a full pipeline discards everything.
        idle_all();
        for (int i = 0; i < 3; i++) begin
            s3_up_valid = 1'b1; s3_up_data = 8'hC0 + 8'(i);
            s1_up_valid = 1'b1; s1_up_data = 8'hD0;
            tick();
        end
        s3_up_valid = 1'b0; s1_up_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_s3_occ", 32'(s3_occ), 32'd3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_s3_dv", 32'(s3_down_valid), 32'd0);
        check("mid_rst_s3_occ", 32'(s3_occ), 32'd0);
        check("mid_rst_s1_dv", 32'(s1_down_valid), 32'd0);
        check("mid_rst_s1_occ", 32'(s1_occ), 32'd0);
`ifdef HS_DELAY_STATS_EN
        check("mid_rst_s3_in", 32'(s3_in_count), 32'd0);
        check("mid_rst_s3_out", 32'(s3_out_count), 32'd0);
        check("mid_rst_s1_in", 32'(s1_in_count), 32'd0);
        check("mid_rst_s1_out", 32'(s1_out_count), 32'd0);
`endif

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            s1_up_valid   = 1'($urandom_range(0, 1));
            s1_up_data    = 8'($urandom_range(0, 255));
            s1_down_ready = ($urandom_range(0, 3) != 0);
            s3_up_valid   = ($urandom_range(0, 3) != 0);
            s3_up_data    = 8'($urandom_range(0, 255));
            s3_down_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(12);
        check("rand_s1_q_empty", 32'(exp_q1.size()), 32'd0);
        check("rand_s3_q_empty", 32'(exp_q3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
